instr_fetch_unit: RTL

//  Fetch stage and IF/ID register of the 5-stage core; supplies the 6-bit OpCode consumed by the opcode decoder.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/pc_next_calc.sv | 23 ++
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit (instr_fetch_unit)
// and its next-PC helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_e;

  localparam logic [5:0]  NOP_OP    = 6'h0e;
  localparam logic [5:0]  OP_J      = 6'h02;
  localparam logic [31:0] INSTR_NOP = {NOP_OP, 26'b0};
  localparam int          PC_INC    = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential PC or J-type target built from
// the upper PC bits of the ID instruction, plus the post-issue increment.
module pc_next_calc
  import ifu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-29:0] region,
  input  logic [25:0]      index,
  input  logic             take_jump,
  output logic [PC_W-1:0]  next_pc,
  output logic [PC_W-1:0]  next_pc_inc
);

  logic [PC_W-1:0] target;

  assign target      = {region, index, 2'b00};
  assign next_pc     = take_jump ? target : pc;
  // Wraps modulo 2^PC_W with no overflow indication.
  assign next_pc_inc = next_pc + PC_W'(PC_INC);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage and IF/ID register with a one-outstanding imem req/valid handshake.
// Optional back-to-back prefetch with jump squash is built when IFU_PREFETCH_EN is defined.
//
// state | meaning
// REQ   | ready to issue a fetch for next_pc (held while Sel_pc_reg=1)
// WAIT  | one fetch outstanding, waiting for imem_valid
// HOLD  | returned word parked in the buffer until IF/ID may load
module instr_fetch_unit
  import ifu_pkg::ifu_state_e, ifu_pkg::REQ, ifu_pkg::WAIT, ifu_pkg::HOLD;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      NOP_OP   = 6'h0e
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Sel_pc_mux,
  input  logic               Sel_pc_reg,
  input  logic               if_id_enable,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [5:0]         OpCode,
  output logic [INSTR_W-1:0] instr_id,
  output logic [PC_W-1:0]    pc_id,
  output logic               id_valid
);

  localparam logic [INSTR_W-1:0] BUBBLE = {NOP_OP, {(INSTR_W-6){1'b0}}};

  ifu_state_e         state, state_nxt;
  logic [PC_W-1:0]    pc, issued_addr, next_pc, next_pc_inc;
  logic [INSTR_W-1:0] buf_data, load_data;
  logic               issue, load, buf_we, take_jump;

`ifdef IFU_PREFETCH_EN
  logic pf_check, squashed, squash_detect, squash_any, load_bubble;

  // The cycle after a prefetch issue is the first one where the decoder sees the freshly loaded word.
  assign squash_detect = pf_check & id_valid & Sel_pc_mux;
  assign squash_any    = squashed | squash_detect;
  assign take_jump     = id_valid & Sel_pc_mux & ((state == REQ) | pf_check);
`else
  assign take_jump     = id_valid & Sel_pc_mux & (state == REQ);
`endif

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc          (pc),
    .region      (pc_id[PC_W-1:28]),
    .index       (instr_id[25:0]),
    .take_jump   (take_jump),
    .next_pc     (next_pc),
    .next_pc_inc (next_pc_inc)
  );

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load      = 1'b0;
    load_data = imem_data;
    buf_we    = 1'b0;
`ifdef IFU_PREFETCH_EN
    load_bubble = 1'b0;
`endif
    case (state)
      REQ: begin
        if (!Sel_pc_reg) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
`ifdef IFU_PREFETCH_EN
        if (imem_valid && squash_any) begin
          load_bubble = !if_id_enable;
          state_nxt   = REQ;
        end else
`endif
        if (imem_valid && !if_id_enable) begin
          load      = 1'b1;
          state_nxt = REQ;
`ifdef IFU_PREFETCH_EN
          if (!Sel_pc_reg) begin
            issue     = 1'b1;
            state_nxt = WAIT;
          end
`endif
        end else if (imem_valid) begin
          buf_we    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!if_id_enable) begin
          load      = 1'b1;
          load_data = buf_data;
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  assign imem_req  = issue & ~rst;
  assign imem_addr = next_pc;
  assign OpCode    = instr_id[INSTR_W-1:INSTR_W-6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      issued_addr <= RESET_PC;
      instr_id    <= BUBBLE;
      pc_id       <= '0;
      id_valid    <= 1'b0;
      buf_data    <= '0;
`ifdef IFU_PREFETCH_EN
      pf_check    <= 1'b0;
      squashed    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (issue) begin
        pc          <= next_pc_inc;
        issued_addr <= next_pc;
      end
`ifdef IFU_PREFETCH_EN
      // Redirect now so the REQ after the bubble fetches the target even once id_valid drops.
      else if (squash_detect) begin
        pc <= next_pc;
      end
`endif
      if (load) begin
        instr_id <= load_data;
        pc_id    <= issued_addr;
        id_valid <= 1'b1;
      end
`ifdef IFU_PREFETCH_EN
      else if (load_bubble) begin
        instr_id <= BUBBLE;
        id_valid <= 1'b0;
      end
      pf_check <= issue & (state == WAIT);
      squashed <= (state == WAIT) & squash_any & ~imem_valid;
`endif
      if (buf_we) begin
        buf_data <= imem_data;
      end
    end
  end

endmodule
